// File: rtl/axi_full_mem_s.sv
// AXI4 full memory slave: independent read and write burst engines
// over a single word array, FIXED/INCR/WRAP addressing, strobed writes.
module axi_full_mem_s #(
  parameter int          DATA_W    = 64,
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int          B     = DATA_W / 8;
  localparam int          SH    = $clog2(B);
  localparam int          IW    = $clog2(MEM_DEPTH);
  localparam logic [31:0] BB    = 32'(B);
  localparam logic [31:0] AMASK = ~(BB - 32'd1);

  typedef enum logic {R_IDLE, R_DATA} r_st_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_t;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  function automatic logic [31:0] nxt_addr(
    input logic [31:0] a,
    input logic [7:0]  len,
    input logic [1:0]  bt
  );
    logic [31:0] sz;
    logic [31:0] msk;
    sz  = ({24'd0, len} + 32'd1) << SH;
    msk = sz - 32'd1;
    unique case (bt)
      2'b01:   nxt_addr = a + BB;
      2'b10:   nxt_addr = (a & ~msk) | ((a + BB) & msk);
      default: nxt_addr = a;
    endcase
  endfunction

  function automatic logic bad_burst(
    input logic [1:0] bt,
    input logic [7:0] len
  );
    bad_burst = (bt == 2'b11) ||
                ((bt == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                    (len == 8'd7) || (len == 8'd15)));
  endfunction

  function automatic logic [31:0] word_idx(input logic [31:0] a);
    word_idx = (a - BASE_ADDR) >> SH;
  endfunction

  // ---------------- read path ----------------
  r_st_t       r_st_q;
  logic [31:0] raddr_q;
  logic [7:0]  rlen_q;
  logic [1:0]  rbt_q;
  logic [7:0]  rcnt_q;
  logic [31:0] r_idx;
  logic        r_ok;
  logic        r_bad;

  assign r_idx   = word_idx(raddr_q);
  assign r_ok    = (raddr_q >= BASE_ADDR) && (r_idx < 32'(MEM_DEPTH));
  assign r_bad   = bad_burst(rbt_q, rlen_q);
  assign arready = (r_st_q == R_IDLE);
  assign rvalid  = (r_st_q == R_DATA);
  assign rlast   = rvalid && (rcnt_q == rlen_q);
  assign rdata   = (rvalid && r_ok && !r_bad) ? mem_q[r_idx[IW-1:0]] : '0;
  assign rresp   = !rvalid ? 2'b00 :
                   r_bad   ? 2'b10 :
                   !r_ok   ? 2'b11 : 2'b00;

  // Read FSM: accept a burst, then step one beat per R handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_q  <= R_IDLE;
      raddr_q <= '0;
      rlen_q  <= '0;
      rbt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      unique case (r_st_q)
        R_IDLE: begin
          if (arvalid) begin
            raddr_q <= araddr & AMASK;
            rlen_q  <= arlen;
            rbt_q   <= arburst;
            rcnt_q  <= '0;
            r_st_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            raddr_q <= nxt_addr(raddr_q, rlen_q, rbt_q);
            rcnt_q  <= rcnt_q + 8'd1;
            if (rcnt_q == rlen_q) r_st_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- write path ----------------
  w_st_t       w_st_q;
  logic [31:0] waddr_q;
  logic [7:0]  wlen_q;
  logic [1:0]  wbt_q;
  logic [8:0]  wcnt_q;
  logic        slv_q;
  logic        dec_q;
  logic [31:0] w_idx;
  logic        w_ok;
  logic        w_bad;
  logic        w_over;
  logic        w_beat;
  logic        w_en;

  assign w_idx   = word_idx(waddr_q);
  assign w_ok    = (waddr_q >= BASE_ADDR) && (w_idx < 32'(MEM_DEPTH));
  assign w_bad   = bad_burst(wbt_q, wlen_q);
  assign w_over  = wcnt_q > {1'b0, wlen_q};
  assign w_beat  = (w_st_q == W_DATA) && wvalid;
  assign w_en    = w_beat && w_ok && !w_bad && !w_over;
  assign awready = (w_st_q == W_IDLE);
  assign wready  = (w_st_q == W_DATA);
  assign bvalid  = (w_st_q == W_RESP);
  assign bresp   = !bvalid ? 2'b00 :
                   slv_q   ? 2'b10 :
                   dec_q   ? 2'b11 : 2'b00;

  // Write FSM: accept a burst, consume beats until wlast, then respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_st_q  <= W_IDLE;
      waddr_q <= '0;
      wlen_q  <= '0;
      wbt_q   <= '0;
      wcnt_q  <= '0;
      slv_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      unique case (w_st_q)
        W_IDLE: begin
          if (awvalid) begin
            waddr_q <= awaddr & AMASK;
            wlen_q  <= awlen;
            wbt_q   <= awburst;
            wcnt_q  <= '0;
            slv_q   <= 1'b0;
            dec_q   <= 1'b0;
            w_st_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            waddr_q <= nxt_addr(waddr_q, wlen_q, wbt_q);
            if (!w_over) wcnt_q <= wcnt_q + 9'd1;
            if (w_bad || w_over) slv_q <= 1'b1;
            if (!w_ok) dec_q <= 1'b1;
            if (wlast) begin
              if (wcnt_q != {1'b0, wlen_q}) slv_q <= 1'b1;
              w_st_q <= W_RESP;
            end else if (wcnt_q >= {1'b0, wlen_q}) begin
              slv_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) w_st_q <= W_IDLE;
        end
        default: w_st_q <= W_IDLE;
      endcase
    end
  end

  // Array write: byte lanes gated by strobes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < B; i++) begin
        if (wstrb[i]) mem_q[w_idx[IW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
